mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch path (PC-driven) and the load/store data path of the single-cycle core.
- Arbitrates between the two requesters and sequences each access with a req/ack handshake to memory.
- Returns read data and a one-cycle done pulse to the winning requester.
- Drives a core-wide stall while any access is outstanding; word-addressed, 32-bit data (PC steps by 1).

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word-addressed memory between instruction fetch and the load/store path.
// Data wins contention until a streak limit forces a waiting fetch through; stuck accesses time out.
module mem_port_arbiter #(
    parameter int unsigned MAX_DM_STREAK = 4,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_IF = 2'd1,
        ACC_DM = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0]  STREAK_MAX = 4'(MAX_DM_STREAK);
    localparam logic [7:0]  TMO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

    state_t      state_q;
    logic [3:0]  streak_q;
    logic [3:0]  streak_d;
    logic [7:0]  tmo_q;
    logic [7:0]  tmo_d;
    logic        grant_dm_d;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] if_rdata_q;
    logic [31:0] dm_rdata_q;
    logic        if_done_q;
    logic        dm_done_q;
    logic        err_q;

    // Arbitration decision and the streak value a data grant would leave behind.
    always_comb begin
        grant_dm_d = dm_req && !(if_req && (streak_q == STREAK_MAX));
        if (!if_req) begin
            streak_d = 4'd0;
        end else if (streak_q == STREAK_MAX) begin
            streak_d = streak_q;
        end else begin
            streak_d = streak_q + 4'd1;
        end
        tmo_d = tmo_q + 8'd1;
    end

    // Access sequencer: grant, hold the memory request, complete on ack or abort on timeout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            streak_q    <= 4'd0;
            tmo_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            if_rdata_q  <= 32'd0;
            dm_rdata_q  <= 32'd0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_dm_d) begin
                        state_q     <= ACC_DM;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_we;
                        mem_addr_q  <= dm_addr;
                        mem_wdata_q <= dm_wdata;
                        tmo_q       <= 8'd0;
                        streak_q    <= streak_d;
                    end else if (if_req) begin
                        state_q     <= ACC_IF;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= 32'd0;
                        tmo_q       <= 8'd0;
                        streak_q    <= 4'd0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACC_IF, ACC_DM: begin
                    // An ack on the final count still wins over the abort.
                    if (mem_ack || (tmo_q == TMO_LAST)) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        if (state_q == ACC_IF) begin
                            if_done_q  <= 1'b1;
                            if_rdata_q <= mem_ack ? mem_rdata : ABORT_DATA;
                        end else begin
                            dm_done_q  <= 1'b1;
                            dm_rdata_q <= mem_ack ? mem_rdata : ABORT_DATA;
                        end
                        if (!mem_ack) begin
                            err_q <= 1'b1;
                        end
                    end
                    tmo_q <= tmo_d;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign err       = err_q;
    assign stall     = (if_req & ~if_done_q) | (dm_req & ~dm_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory responder predicts each grant and its outcome,
// a separate monitor pops the expectation whenever a done pulse appears.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = 32'd0;
    logic [31:0] dm_wdata = 32'd0;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic        stall;
    logic        err;

    mem_port_arbiter #(.MAX_DM_STREAK(MAXS), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        if_q[$];
    exp_t        dm_q[$];
    bit          grant_log[$];
    int          checks = 0;
    int          errors = 0;
    int          streak_m = 0;
    bit          err_m = 1'b0;
    int          fix_delay = 0;
    bit          fix_data_en = 1'b0;
    logic [31:0] fix_data = 32'd0;
    logic [31:0] if_cur_addr = 32'd0;
    logic        dm_cur_we = 1'b0;
    logic [31:0] dm_cur_addr = 32'd0;
    logic [31:0] dm_cur_wdata = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder + reference model: predicts the winner from the arbitration rule.
    initial begin : responder
        bit          win_dm;
        bit          ab;
        int          d;
        int          r;
        logic [31:0] data;
        logic [31:0] a0;
        logic [31:0] w0;
        logic        we0;
        exp_t        e;
        forever begin
            @(posedge clock); #1;
            if (!reset && mem_req) begin
                win_dm = dm_req && !(if_req && (streak_m == MAXS));
                grant_log.push_back(win_dm);
                if (win_dm) begin
                    chk("grant_dm_addr", mem_addr, dm_cur_addr);
                    chk("grant_dm_we", {31'd0, mem_we}, {31'd0, dm_cur_we});
                    if (dm_cur_we) chk("grant_dm_wdata", mem_wdata, dm_cur_wdata);
                    if (if_req) streak_m = (streak_m < MAXS) ? streak_m + 1 : streak_m;
                    else streak_m = 0;
                end else begin
                    chk("grant_if_req", {31'd0, if_req}, 32'd1);
                    chk("grant_if_addr", mem_addr, if_cur_addr);
                    chk("grant_if_we", {31'd0, mem_we}, 32'd0);
                    streak_m = 0;
                end
                if (fix_delay >= 0) begin
                    d = fix_delay;
                end else begin
                    r = $urandom_range(0, 15);
                    d = (r == 15) ? 9 : ((r == 14) ? TMO - 1 : r % 4);
                end
                data = fix_data_en ? fix_data : $urandom;
                a0 = mem_addr; we0 = mem_we; w0 = mem_wdata;
                if (d >= TMO) err_m = 1'b1;
                e.data = (d < TMO) ? data : 32'hDEADBEEF;
                e.err  = err_m;
                if (win_dm) dm_q.push_back(e);
                else if_q.push_back(e);
                ab = 1'b0;
                if (d < TMO) begin
                    for (int i = 0; i < d; i++) begin
                        @(posedge clock); #1;
                        if (reset) begin ab = 1'b1; break; end
                        chk("hold_stable", {31'd0, (mem_req === 1'b1 && mem_we === we0 &&
                            mem_addr === a0 && mem_wdata === w0)}, 32'd1);
                    end
                    if (!ab) begin
                        @(negedge clock); mem_ack = 1'b1; mem_rdata = data;
                        @(negedge clock); mem_ack = 1'b0; mem_rdata = $urandom;
                        if (!reset) chk("ack_drop_req", {31'd0, mem_req}, 32'd0);
                    end
                end else begin
                    for (int i = 1; i <= TMO; i++) begin
                        @(posedge clock); #1;
                        if (reset) begin ab = 1'b1; break; end
                        chk("tmo_req_window", {31'd0, mem_req}, 32'(i < TMO));
                    end
                    if (!ab) begin
                        @(negedge clock); mem_ack = 1'b1; mem_rdata = 32'h0BAD0BAD;
                        @(negedge clock); mem_ack = 1'b0;
                    end
                end
            end
        end
    end

    // Done monitor: pops the expectation for whichever requester completes.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock); #1;
            if (if_done) begin
                if (if_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL if_done_unexpected: got 1 expected 0 at %0t", $time);
                end else begin
                    e = if_q.pop_front();
                    chk("if_rdata", if_rdata, e.data);
                    chk("if_err", {31'd0, err}, {31'd0, e.err});
                end
            end
            if (dm_done) begin
                if (dm_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dm_done_unexpected: got 1 expected 0 at %0t", $time);
                end else begin
                    e = dm_q.pop_front();
                    chk("dm_rdata", dm_rdata, e.data);
                    chk("dm_err", {31'd0, err}, {31'd0, e.err});
                end
            end
        end
    end

    task automatic fetch_txn(input logic [31:0] a, input bit keep, output int n);
        @(negedge clock);
        if_req = 1'b1; if_addr = a; if_cur_addr = a;
        n = 0;
        do begin @(posedge clock); #1; n++; end while (!if_done && n < 300);
        chk("fetch_wait", {31'd0, if_done}, 32'd1);
        if (!keep) begin @(negedge clock); if_req = 1'b0; end
    endtask

    task automatic data_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input bit keep, output int n);
        @(negedge clock);
        dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
        dm_cur_we = we; dm_cur_addr = a; dm_cur_wdata = wd;
        n = 0;
        do begin @(posedge clock); #1; n++; end while (!dm_done && n < 300);
        chk("data_wait", {31'd0, dm_done}, 32'd1);
        if (!keep) begin @(negedge clock); dm_req = 1'b0; end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin : main
        int n;
        bit exp_order[10];
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_done", {30'd0, if_done, dm_done}, 32'd0);
        chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
        chk("rst_err_stall", {30'd0, err, stall}, 32'd0);
        @(negedge clock); reset = 1'b0;

        // Fetch only, zero-wait memory
        fix_delay = 0; fix_data_en = 1'b1; fix_data = 32'h8C220004;
        fetch_txn(32'h10, 1'b0, n);
        chk("fetch_latency", n, 32'd2);
        @(posedge clock); #1;
        chk("fetch_done_one_cycle", {31'd0, if_done}, 32'd0);
        chk("fetch_stall_after", {31'd0, stall}, 32'd0);

        // Store with 5 wait cycles
        fix_delay = 5; fix_data = 32'h5555AAAA;
        data_txn(1'b1, 32'h20, 32'hCAFEF00D, 1'b0, n);
        chk("store_latency", n, 32'd7);

        // Contention with continuous requests
        fix_delay = 0; fix_data_en = 1'b0;
        grant_log.delete();
        fork
            begin
                int m;
                fetch_txn(32'h100, 1'b1, m);
                fetch_txn(32'h101, 1'b0, m);
            end
            begin
                int m;
                for (int i = 0; i < 8; i++) data_txn(1'b0, 32'h200 + 32'(i), 32'd0, i < 7, m);
            end
        join
        chk("contention_count", grant_log.size(), 32'd10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            chk($sformatf("contention_grant_%0d", i), {31'd0, grant_log[i]}, {31'd0, exp_order[i]});

        // Timeout, then err stays sticky through good accesses
        fix_delay = 9;
        data_txn(1'b0, 32'h30, 32'd0, 1'b0, n);
        chk("tmo_err_set", {31'd0, err}, 32'd1);
        fix_delay = 1;
        fetch_txn(32'h31, 1'b0, n);
        data_txn(1'b1, 32'h32, 32'h77, 1'b0, n);
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Reset in the middle of a data access
        fix_delay = 9;
        @(negedge clock);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
        dm_cur_we = 1'b0; dm_cur_addr = 32'h44; dm_cur_wdata = 32'd0;
        n = 0;
        while (!mem_req && n < 20) begin @(posedge clock); #1; n++; end
        chk("rst_mid_granted", {31'd0, mem_req}, 32'd1);
        repeat (3) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_dm_done", {31'd0, dm_done}, 32'd0);
        chk("rst_mid_err", {31'd0, err}, 32'd0);
        dm_q.delete(); if_q.delete(); err_m = 1'b0; streak_m = 0;
        dm_req = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b0;
        fix_delay = 0;
        fetch_txn(32'h48, 1'b0, n);
        chk("post_rst_latency", n, 32'd2);

        // Ack on the same edge the count reaches the limit
        fix_delay = TMO - 1; fix_data_en = 1'b1; fix_data = 32'h1234;
        data_txn(1'b0, 32'h50, 32'd0, 1'b0, n);
        chk("boundary_err", {31'd0, err}, 32'd0);

        // Randomized traffic
        fix_delay = -1; fix_data_en = 1'b0;
        fork
            begin
                int m;
                for (int i = 0; i < 15; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clock);
                    fetch_txn($urandom, 1'b0, m);
                end
            end
            begin
                int m;
                for (int i = 0; i < 15; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clock);
                    data_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0, m);
                end
            end
        join
        repeat (20) @(posedge clock);
        #1;
        chk("if_queue_empty", if_q.size(), 32'd0);
        chk("dm_queue_empty", dm_q.size(), 32'd0);
        chk("final_err", {31'd0, err}, {31'd0, err_m});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
